// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and constants for the 7-segment scan path.
// Segment vectors are active-low, bit order {g,f,e,d,c,b,a}.
package seg_scan_pkg;

  typedef enum logic {
    GUARD = 1'b0,
    ON    = 1'b1
  } state_t;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Index 15 is listed first so HEX_SEG[n] is the code for nibble n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: combinational hex nibble to active-low segment decode.
// Output bit order {g,f,e,d,c,b,a}.
module hex_to_seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit multiplexed display scanner with guard gaps.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading-zero digits.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int TICK_DIV     = 104_166,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    load_ack,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              cathode,
  output logic                    dp_n
);

  localparam int CMAX =
    (TICK_DIV > GUARD_CYCLES) ? TICK_DIV : GUARD_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] G_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TICK_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0]   shadow_dp;

  logic [3:0]              nib;
  logic                    dp_sel;
  logic [NUM_DIGITS-1:0]   sel;
  logic [NUM_DIGITS-1:0]   blank;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   on_anode;

  // Pick the nibble, dp bit and one-hot anode for the current slot.
  always_comb begin
    nib    = 4'h0;
    dp_sel = 1'b0;
    sel    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib    = shadow[4*i +: 4];
        dp_sel = shadow_dp[i];
        sel[i] = 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zrun;

  // Blank a digit when it and every higher shadow nibble are zero.
  always_comb begin
    blank = '0;
    zrun  = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zrun     = zrun & (shadow[4*i +: 4] == 4'h0);
      blank[i] = zrun;
    end
  end
`else
  assign blank = '0;
`endif

  hex_to_seg u_hex (
    .nibble (nib),
    .seg    (seg)
  );

  assign on_anode = ~(sel & digit_en & ~blank);

  // Slot sequencer: guard gap, then one digit on, frame-aligned load.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state     <= GUARD;
      cnt       <= '0;
      idx       <= '0;
      shadow    <= '0;
      shadow_dp <= '0;
      load_ack  <= 1'b0;
      anode     <= '1;
      cathode   <= SEG_OFF;
      dp_n      <= 1'b1;
    end else begin
      load_ack <= 1'b0;
      unique case (state)
        GUARD: begin
          if (cnt == G_LAST) begin
            state   <= ON;
            cnt     <= '0;
            anode   <= on_anode;
            cathode <= seg;
            dp_n    <= ~dp_sel;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ON: begin
          if (cnt == T_LAST) begin
            state   <= GUARD;
            cnt     <= '0;
            idx     <= (idx == I_LAST) ? '0 : idx + IW'(1);
            anode   <= '1;
            cathode <= SEG_OFF;
            dp_n    <= 1'b1;
            if (idx == I_LAST && load) begin
              shadow    <= data_in;
              shadow_dp <= dp_in;
              load_ack  <= 1'b1;
            end
          end else begin
            cnt     <= cnt + CW'(1);
            anode   <= on_anode;
            cathode <= seg;
            dp_n    <= ~dp_sel;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized scenario bench for seg_scan_ctrl.
// Reference model derives outputs from cycle count since reset.
module tb_seg_scan_ctrl;

  localparam int N     = 8;
  localparam int T     = 4;
  localparam int G     = 2;
  localparam int SLOT  = T + G;
  localparam int FRAME = N * SLOT;

  logic           clk_in   = 1'b0;
  logic           reset    = 1'b1;
  logic [4*N-1:0] data_in  = '0;
  logic [N-1:0]   dp_in    = '0;
  logic           load     = 1'b0;
  logic [N-1:0]   digit_en = '1;
  logic           load_ack;
  logic [N-1:0]   anode;
  logic [6:0]     cathode;
  logic           dp_n;

  int tests = 0;
  int fails = 0;
  int k     = 0;

  logic [4*N-1:0] m_data = '0;
  logic [N-1:0]   m_dp   = '0;
  logic           e_ack  = 1'b0;
  logic [16:0]    want   = {8'hFF, 7'h7F, 1'b1, 1'b0};
  logic [16:0]    obs;

  localparam logic [16:0] OFF_VEC = {8'hFF, 7'h7F, 1'b1, 1'b0};

  assign obs = {anode, cathode, dp_n, load_ack};

  seg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .TICK_DIV     (T),
    .GUARD_CYCLES (G)
  ) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .data_in  (data_in),
    .dp_in    (dp_in),
    .load     (load),
    .digit_en (digit_en),
    .load_ack (load_ack),
    .anode    (anode),
    .cathode  (cathode),
    .dp_n     (dp_n)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Advance one clock and compute what the display must show now.
  task automatic step();
    int slot;
    logic [N-1:0] onehot;
    @(posedge clk_in);
    #1;
    if (reset) begin
      k      = 0;
      m_data = '0;
      m_dp   = '0;
      e_ack  = 1'b0;
    end else begin
      k++;
      e_ack = (k % FRAME == 0) && load;
      if (e_ack) begin
        m_data = data_in;
        m_dp   = dp_in;
      end
    end
    slot   = (k / SLOT) % N;
    onehot = N'(1) << slot;
    if (!reset && (k % SLOT) >= G)
      want = {~(onehot & digit_en), seg_of(m_data[4*slot +: 4]),
              ~m_dp[slot], e_ack};
    else
      want = {8'hFF, 7'h7F, 1'b1, e_ack};
  endtask

  task automatic goto_slot(input int s);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(((k / SLOT) % N == s) && (k % SLOT >= G))
               && n < 2 * FRAME);
    if (n >= 2 * FRAME) begin
      tests++;
      fails++;
      $display("FAIL goto_slot %0d timeout", s);
    end
  endtask

  task automatic test_reset();
    logic [16:0] fixed;
    reset    = 1'b1;
    load     = 1'b0;
    digit_en = '1;
    repeat (3) begin
      step();
      tests++;
      if (obs !== OFF_VEC) begin
        fails++;
        $display("FAIL reset_hold got %h exp %h", obs, OFF_VEC);
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      fixed = (i >= 2 && i <= 5) ?
        {8'hFE, 7'b1000000, 1'b1, 1'b0} : OFF_VEC;
      tests++;
      if (obs !== fixed) begin
        fails++;
        $display("FAIL reset_release c%0d got %h exp %h",
                 i, obs, fixed);
      end
    end
  endtask

  task automatic test_scan();
    int n = 0;
    data_in = 32'h76543210;
    dp_in   = N'($urandom);
    load    = 1'b1;
    do begin
      step();
      n++;
      tests++;
      if (obs !== want) begin
        fails++;
        $display("FAIL scan_load k=%0d got %h exp %h", k, obs, want);
      end
    end while (!e_ack && n < 2 * FRAME);
    if (!e_ack) begin
      tests++;
      fails++;
      $display("FAIL scan_ack timeout got 0 exp 1");
    end
    load = 1'b0;
    repeat (FRAME + SLOT) begin
      step();
      tests++;
      if (obs !== want) begin
        fails++;
        $display("FAIL scan k=%0d got %h exp %h", k, obs, want);
      end
    end
  endtask

  task automatic test_midframe_load();
    int n = 0;
    goto_slot(3);
    data_in = 32'hDEADBEEF;
    dp_in   = N'($urandom);
    load    = 1'b1;
    do begin
      step();
      n++;
      tests++;
      if (obs !== want) begin
        fails++;
        $display("FAIL mid_load k=%0d got %h exp %h", k, obs, want);
      end
    end while (!e_ack && n < 2 * FRAME);
    tests++;
    if (load_ack !== 1'b1) begin
      fails++;
      $display("FAIL mid_ack got %b exp 1", load_ack);
    end
    load = 1'b0;
    n    = 0;
    do begin
      step();
      n++;
      tests++;
      if (obs !== want) begin
        fails++;
        $display("FAIL mid_after k=%0d got %h exp %h", k, obs, want);
      end
    end while (k % FRAME != G && n < 2 * FRAME);
    tests++;
    if (cathode !== 7'b0001110) begin
      fails++;
      $display("FAIL mid_digit0 got %b exp 0001110", cathode);
    end
  endtask

  task automatic test_load_drop();
    goto_slot(2);
    data_in = 32'($urandom);
    load    = 1'b1;
    while ((k / SLOT) % N != 5) begin
      step();
      tests++;
      if (obs !== want) begin
        fails++;
        $display("FAIL drop_hold k=%0d got %h exp %h", k, obs, want);
      end
    end
    load = 1'b0;
    repeat (2 * FRAME) begin
      step();
      tests++;
      if (obs !== want || load_ack !== 1'b0) begin
        fails++;
        $display("FAIL drop k=%0d got %h exp %h", k, obs, want);
      end
    end
  endtask

  task automatic test_digit_en();
    digit_en = 8'h0F;
    repeat (FRAME) begin
      step();
      tests++;
      if (obs !== want || anode[7:4] !== 4'hF) begin
        fails++;
        $display("FAIL digit_en k=%0d got %h exp %h", k, obs, want);
      end
    end
    digit_en = '1;
  endtask

  task automatic test_random();
    repeat (4 * FRAME) begin
      if ($urandom_range(15) == 0)
        digit_en = N'($urandom);
      if (!load && $urandom_range(7) == 0) begin
        data_in = 32'($urandom);
        dp_in   = N'($urandom);
        load    = 1'b1;
      end else if (load && $urandom_range(9) == 0) begin
        load = 1'b0;
      end
      step();
      tests++;
      if (obs !== want) begin
        fails++;
        $display("FAIL random k=%0d got %h exp %h", k, obs, want);
      end
    end
    load     = 1'b0;
    digit_en = '1;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    load = 1'b0;
    goto_slot(5);
    data_in = 32'($urandom);
    load    = 1'b1;
    reset   = 1'b1;
    step();
    tests++;
    if (obs !== OFF_VEC) begin
      fails++;
      $display("FAIL rst_mid got %h exp %h", obs, OFF_VEC);
    end
    reset = 1'b0;
    load  = 1'b0;
    do begin
      step();
      n++;
      tests++;
      if (obs !== want) begin
        fails++;
        $display("FAIL rst_after k=%0d got %h exp %h", k, obs, want);
      end
    end while (k != G && n < FRAME);
    tests++;
    if (anode !== 8'hFE || cathode !== 7'b1000000) begin
      fails++;
      $display("FAIL rst_digit0 got %h/%b exp fe/1000000",
               anode, cathode);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_midframe_load();
    test_load_drop();
    test_digit_en();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
